ifft_r2dit: RTL and testbench
=============================

IFFT_R2DIT -- requirements
Module: ifft_r2dit

Interface
REQ-001 Parameter N, default 256, transform length; SHALL be a power of two.
REQ-002 Parameter DW, default 16, sample width, signed two's complement, Q1.15.
REQ-003 Parameter LOGN, default 8, log2(N), number of stages.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 x_re  in  DW  frequency bin, real part.
REQ-007 x_im  in  DW  frequency bin, imaginary part.
REQ-008 x_valid  in  1  bin present on x_re/x_im.
REQ-009 x_last  in  1  marks bin N-1 of a frame.
REQ-010 x_ready  out  1  block accepts a bin this cycle; a bin transfers when x_valid and x_ready are both high.
REQ-011 y_re  out  DW  time sample, real part.
REQ-012 y_im  out  DW  time sample, imaginary part.
REQ-013 y_valid  out  1  one-cycle strobe per output sample.
REQ-014 y_last  out  1  high with y_valid on sample N-1.
REQ-015 frame_err  out  1  one-cycle pulse on frame-length violation.

Function
REQ-016 States SHALL be IDLE, LOAD, COMPUTE, OUTPUT; x_ready SHALL be high only in IDLE and LOAD.
REQ-017 Transferred bin k (k = 0..N-1, in arrival order) SHALL be written to RAM address bitrev(k); x_valid gaps SHALL stall the count without loss.
REQ-018 IDLE->LOAD on the first transfer; LOAD->COMPUTE on the transfer of bin N-1.
REQ-019 x_last on bin k < N-1: frame_err pulses, the frame is discarded, the FSM returns to IDLE, and no y_valid is produced.
REQ-020 Bin N-1 transferred without x_last: frame_err pulses and the frame is still processed.
REQ-021 COMPUTE SHALL perform one radix-2 DIT butterfly per cycle in place: stages 0..LOGN-1, N/2 butterflies each, 1024 cycles for N=256.
REQ-022 Butterfly indices for stage s, count c: half=2^s, a=(c>>s)*2*half+(c mod half), b=a+half, twiddle index t=(c mod half)*(N/2>>s).
REQ-023 Twiddle SHALL be conjugate of forward: W_re=trunc(cos(2*pi*t/N)*32767), W_im=+trunc(sin(2*pi*t/N)*32767).
REQ-024 wb=W*b as full 2*DW products, arithmetic >>15 to DW bits.
REQ-025 Outputs p=(a+wb)>>>1 and q=(a-wb)>>>1, computed at DW+1 bits before the shift; this gives a total scaling of 1/N and no overflow.
REQ-026 OUTPUT SHALL stream RAM addresses 0..N-1, one per cycle, registered onto y_re/y_im with y_valid high, then return to IDLE.
REQ-027 Latency: with the bin N-1 transfer at edge T, the first y_valid SHALL be high after edge T+1025 and y_last high after edge T+1280 (N=256).
REQ-028 x_valid during COMPUTE/OUTPUT SHALL be ignored (x_ready low) and SHALL NOT raise frame_err.
REQ-029 y_valid, y_last and frame_err SHALL default low every cycle unless asserted.

Reset
REQ-030 On rst_n low, asynchronously: state=IDLE; all counters=0; y_re=y_im=0; y_valid=y_last=frame_err=0; x_ready=0 while rst_n is low, then 1 on the first cycle after release.
REQ-031 Reset during any state SHALL abandon the frame; RAM contents need not be cleared.

Structure
REQ-032 Shared package fft_pkg SHALL hold N, DW, LOGN, the state encoding and the bitrev function; the forward FFT SHALL reuse it.
REQ-033 Twiddle ROM SHALL be sub-module fft_twiddle_rom (N/2 entries, parameter CONJ selecting the sign of W_im), shared with the forward FFT.

Verification
REQ-034 DC: bin0=(32767,0), others 0 -> all 256 outputs y=(127,0); y_last only on sample 255.
REQ-035 Tone: bin1=(32767,0), others 0 -> y[0]~(127,0), y[64]~(0,127), y[128]~(-127,0), each within +/-2 LSB of a bit-accurate model.
REQ-036 Short frame: x_last on bin 100 -> frame_err single pulse, no y_valid; the next full DC frame gives REQ-034 output.
REQ-037 Throttled input: x_valid high 1 cycle in 3 for a REQ-035 frame -> identical output; latency per REQ-027 from the last transfer.
REQ-038 Reset asserted at COMPUTE cycle 500 -> outputs zero immediately, x_ready=1 after release, next frame correct.
REQ-039 Missing x_last on bin 255 -> frame_err pulse, and 256 outputs still produced.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT forward and inverse FFT blocks.
// Holds the default transform sizing, the control state encoding and bit reversal.
package fft_pkg;

    localparam int unsigned FFT_N    = 256;
    localparam int unsigned FFT_DW   = 16;
    localparam int unsigned FFT_LOGN = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_OUTPUT  = 2'd3
    } fft_state_e;

    // Reverse the low 'bits' bits of k; bits above that are dropped.
    function automatic int unsigned bitrev(input int unsigned k, input int unsigned bits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < bits) begin
                r = r | (((k >> i) & 32'd1) << (bits - 1 - i));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Twiddle factor ROM, N/2 entries of cos/sin(2*pi*t/N) scaled by 2^(DW-1)-1 and truncated.
// CONJ=1 gives +sin (inverse transform), CONJ=0 gives -sin (forward transform).
module fft_twiddle_rom #(
    parameter int unsigned N    = fft_pkg::FFT_N,
    parameter int unsigned DW   = fft_pkg::FFT_DW,
    parameter bit          CONJ = 1'b1
) (
    input  logic [$clog2(N)-2:0] i_idx,
    output logic signed [DW-1:0] o_w_re_c,
    output logic signed [DW-1:0] o_w_im_c
);

    localparam real PI  = 3.14159265358979323846;
    localparam real AMP = real'((2 ** (DW - 1)) - 1);

    logic signed [DW-1:0] w_tab_re [N/2];
    logic signed [DW-1:0] w_tab_im [N/2];

    // Table contents are fixed at elaboration; $rtoi truncates toward zero.
    for (genvar g = 0; g < N / 2; g++) begin : g_tab
        localparam real ANG  = 2.0 * PI * real'(g) / real'(N);
        localparam int  RE_I = $rtoi($cos(ANG) * AMP);
        localparam int  IM_I = $rtoi($sin(ANG) * AMP);
        assign w_tab_re[g] = DW'(RE_I);
        assign w_tab_im[g] = CONJ ? DW'(IM_I) : DW'(-IM_I);
    end

    assign o_w_re_c = w_tab_re[i_idx];
    assign o_w_im_c = w_tab_im[i_idx];

endmodule

// File: rtl/ifft_r2dit.sv
// In-place radix-2 DIT inverse FFT: bit-reversed load, one butterfly per cycle with
// 1/2 scaling per stage (1/N overall), then natural-order streaming of the result.
module ifft_r2dit
    import fft_pkg::*;
#(
    parameter int unsigned N    = FFT_N,
    parameter int unsigned DW   = FFT_DW,
    parameter int unsigned LOGN = FFT_LOGN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] x_re,
    input  logic signed [DW-1:0] x_im,
    input  logic                 x_valid,
    input  logic                 x_last,
    output logic                 x_ready,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im,
    output logic                 y_valid,
    output logic                 y_last,
    output logic                 frame_err
);

    localparam int unsigned SW = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam int unsigned CW = LOGN - 1;

    fft_state_e r_state, w_next_state;

    logic [LOGN-1:0]      r_cnt;
    logic [CW-1:0]        r_bfly;
    logic [SW-1:0]        r_stage;
    logic                 r_x_ready, r_y_valid, r_y_last, r_frame_err;
    logic signed [DW-1:0] r_y_re, r_y_im;
    logic signed [DW-1:0] r_ram_re [N];
    logic signed [DW-1:0] r_ram_im [N];

    logic                 w_xfer, w_frame_err, w_bfly_last;
    logic [LOGN-1:0]      w_load_addr, w_c_ext, w_half, w_low, w_addr_a, w_addr_b;
    logic [CW-1:0]        w_tw_idx;
    logic signed [DW-1:0] w_tw_re, w_tw_im, w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [DW-1:0] w_wb_re, w_wb_im, w_p_re, w_p_im, w_q_re, w_q_im;
    logic signed [2*DW-1:0] w_m_rr, w_m_ii, w_m_ri, w_m_ir;
    logic signed [2*DW:0]   w_wb_re_full, w_wb_im_full;
    logic signed [DW:0]     w_sp_re, w_sp_im, w_sq_re, w_sq_im;

    assign w_xfer      = x_valid & r_x_ready;
    assign w_load_addr = LOGN'(bitrev(32'(r_cnt), LOGN));
    assign w_bfly_last = (&r_bfly) && (r_stage == SW'(LOGN - 1));

    // Butterfly addressing: a = (c >> s) * 2^(s+1) + (c mod 2^s), b = a + 2^s.
    assign w_c_ext  = LOGN'(r_bfly);
    assign w_half   = LOGN'(1) << r_stage;
    assign w_low    = w_c_ext & (w_half - LOGN'(1));
    assign w_addr_a = ((w_c_ext - w_low) << 1) | w_low;
    assign w_addr_b = w_addr_a | w_half;
    assign w_tw_idx = CW'(w_low << (SW'(LOGN - 1) - r_stage));

    fft_twiddle_rom #(
        .N   (N),
        .DW  (DW),
        .CONJ(1'b1)
    ) u_twiddle_rom (
        .i_idx   (w_tw_idx),
        .o_w_re_c(w_tw_re),
        .o_w_im_c(w_tw_im)
    );

    assign w_a_re = r_ram_re[w_addr_a];
    assign w_a_im = r_ram_im[w_addr_a];
    assign w_b_re = r_ram_re[w_addr_b];
    assign w_b_im = r_ram_im[w_addr_b];

    // Complex product at full precision, then back to Q1.15.
    assign w_m_rr       = (2*DW)'(w_tw_re) * (2*DW)'(w_b_re);
    assign w_m_ii       = (2*DW)'(w_tw_im) * (2*DW)'(w_b_im);
    assign w_m_ri       = (2*DW)'(w_tw_re) * (2*DW)'(w_b_im);
    assign w_m_ir       = (2*DW)'(w_tw_im) * (2*DW)'(w_b_re);
    assign w_wb_re_full = (2*DW+1)'(w_m_rr) - (2*DW+1)'(w_m_ii);
    assign w_wb_im_full = (2*DW+1)'(w_m_ri) + (2*DW+1)'(w_m_ir);
    assign w_wb_re      = DW'(w_wb_re_full >>> (DW - 1));
    assign w_wb_im      = DW'(w_wb_im_full >>> (DW - 1));

    assign w_sp_re = (DW+1)'(w_a_re) + (DW+1)'(w_wb_re);
    assign w_sp_im = (DW+1)'(w_a_im) + (DW+1)'(w_wb_im);
    assign w_sq_re = (DW+1)'(w_a_re) - (DW+1)'(w_wb_re);
    assign w_sq_im = (DW+1)'(w_a_im) - (DW+1)'(w_wb_im);
    assign w_p_re  = DW'(w_sp_re >>> 1);
    assign w_p_im  = DW'(w_sp_im >>> 1);
    assign w_q_re  = DW'(w_sq_re >>> 1);
    assign w_q_im  = DW'(w_sq_im >>> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Frame-length checking happens on the transfer that ends or overruns the frame.
    always_comb begin
        w_next_state = r_state;
        w_frame_err  = 1'b0;
        case (r_state)
            ST_IDLE, ST_LOAD: begin
                if (w_xfer) begin
                    if (r_cnt == LOGN'(N - 1)) begin
                        w_next_state = ST_COMPUTE;
                        w_frame_err  = ~x_last;
                    end else if (x_last) begin
                        w_next_state = ST_IDLE;
                        w_frame_err  = 1'b1;
                    end else begin
                        w_next_state = ST_LOAD;
                    end
                end
            end
            ST_COMPUTE: if (w_bfly_last) w_next_state = ST_OUTPUT;
            ST_OUTPUT:  if (r_cnt == LOGN'(N - 1)) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_bfly      <= '0;
            r_stage     <= '0;
            r_x_ready   <= 1'b0;
            r_y_valid   <= 1'b0;
            r_y_last    <= 1'b0;
            r_frame_err <= 1'b0;
            r_y_re      <= '0;
            r_y_im      <= '0;
        end else begin
            r_x_ready   <= (w_next_state == ST_IDLE) || (w_next_state == ST_LOAD);
            r_frame_err <= w_frame_err;
            r_y_valid   <= (r_state == ST_OUTPUT);
            r_y_last    <= (r_state == ST_OUTPUT) && (r_cnt == LOGN'(N - 1));
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_xfer) r_cnt <= (w_next_state == ST_LOAD) ? r_cnt + LOGN'(1) : '0;
                end
                ST_COMPUTE: begin
                    r_bfly <= r_bfly + CW'(1);
                    if (&r_bfly) r_stage <= w_bfly_last ? '0 : r_stage + SW'(1);
                end
                ST_OUTPUT: begin
                    r_y_re <= r_ram_re[r_cnt];
                    r_y_im <= r_ram_im[r_cnt];
                    r_cnt  <= r_cnt + LOGN'(1);
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Sample memory; loads and butterflies never overlap, so the ports never collide.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_ram_re[w_load_addr] <= x_re;
            r_ram_im[w_load_addr] <= x_im;
        end
        if (r_state == ST_COMPUTE) begin
            r_ram_re[w_addr_a] <= w_p_re;
            r_ram_im[w_addr_a] <= w_p_im;
            r_ram_re[w_addr_b] <= w_q_re;
            r_ram_im[w_addr_b] <= w_q_im;
        end
    end

    assign x_ready   = r_x_ready;
    assign y_re      = r_y_re;
    assign y_im      = r_y_im;
    assign y_valid   = r_y_valid;
    assign y_last    = r_y_last;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ifft_r2dit.sv
// Bench for ifft_r2dit: table of impulse frames checked against a reference IFFT
// model through an output scoreboard, plus a reset-during-compute sequence.
module tb_ifft_r2dit;

    localparam int NN = 256;

    logic               clk, rst_n;
    logic signed [15:0] x_re, x_im, y_re, y_im;
    logic               x_valid, x_last, x_ready, y_valid, y_last, frame_err;

    ifft_r2dit #(.N(256), .DW(16), .LOGN(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .x_re(x_re), .x_im(x_im), .x_valid(x_valid), .x_last(x_last), .x_ready(x_ready),
        .y_re(y_re), .y_im(y_im), .y_valid(y_valid), .y_last(y_last), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    bin;
        int    gap;
        int    nbins;
        int    last_idx;
        int    exp_err;
        int    exp_nout;
        int    probe_n;
        int    probe_re;
        int    probe_im;
    } vec_t;

    typedef struct {
        int re;
        int im;
        bit last;
    } exp_t;

    vec_t vecs[7];
    exp_t sb_q[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, t_xfer = 0, t_first = -1, t_lastout = -1;
    int   out_idx = 0, n_err_pulse = 0;
    int   cap_re[NN], cap_im[NN], m_re[NN], m_im[NN];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int brev8(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) r = r | (((k >> i) & 1) << (7 - i));
        return r;
    endfunction

    // Reference inverse DIT FFT of a single full-scale impulse at 'bin'.
    function automatic void run_model(input int bin);
        int half, a, b, t, wr, wi, wbr, wbi, ar, ai, br, bi;
        longint pr, pi;
        real ang;
        for (int i = 0; i < NN; i++) begin m_re[i] = 0; m_im[i] = 0; end
        m_re[brev8(bin)] = 32767;
        for (int s = 0; s < 8; s++) begin
            half = 1 << s;
            for (int g = 0; g < NN; g += 2 * half) begin
                for (int j = 0; j < half; j++) begin
                    t   = j * (128 >> s);
                    ang = 2.0 * 3.14159265358979323846 * real'(t) / 256.0;
                    wr  = $rtoi($cos(ang) * 32767.0);
                    wi  = $rtoi($sin(ang) * 32767.0);
                    a = g + j; b = a + half;
                    ar = m_re[a]; ai = m_im[a]; br = m_re[b]; bi = m_im[b];
                    pr  = longint'(wr) * br - longint'(wi) * bi;
                    pi  = longint'(wr) * bi + longint'(wi) * br;
                    wbr = int'(shortint'(pr >>> 15));
                    wbi = int'(shortint'(pi >>> 15));
                    m_re[a] = (ar + wbr) >>> 1; m_im[a] = (ai + wbi) >>> 1;
                    m_re[b] = (ar - wbr) >>> 1; m_im[b] = (ai - wbi) >>> 1;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp, input int tol);
        checks++;
        if (absd(act, exp) > tol) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Output monitor and scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (frame_err) n_err_pulse++;
            if (y_valid) begin
                if (out_idx == 0) t_first = cyc;
                if (y_last) t_lastout = cyc;
                if (out_idx < NN) begin
                    cap_re[out_idx] = int'(y_re);
                    cap_im[out_idx] = int'(y_im);
                end
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_y_valid sample %0d actual (%0d,%0d) expected none", out_idx, y_re, y_im);
                end else begin
                    e = sb_q.pop_front();
                    if (absd(int'(y_re), e.re) > 2 || absd(int'(y_im), e.im) > 2 || y_last != e.last) begin
                        errors++;
                        $display("FAIL sample_%0d actual (%0d,%0d,last=%0b) expected (%0d,%0d,last=%0b)",
                                 out_idx, y_re, y_im, y_last, e.re, e.im, e.last);
                    end
                end
                out_idx++;
            end
        end
    end

    task automatic send_frame(input int bin, input int gap, input int nbins, input int last_idx);
        int b;
        for (int k = 0; k < nbins; k++) begin
            @(negedge clk);
            x_valid = 1'b1;
            x_re    = (k == bin) ? 16'sd32767 : 16'sd0;
            x_im    = 16'sd0;
            x_last  = (k == last_idx);
            b = 0;
            while (!x_ready && b < 2000) begin @(negedge clk); b++; end
            if (b >= 2000) begin
                chk("x_ready_timeout", 0, 1, 0);
                x_valid = 1'b0;
                return;
            end
            t_xfer = cyc;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                x_valid = 1'b0;
                x_last  = 1'b0;
            end
        end
        @(negedge clk);
        x_valid = 1'b0;
        x_last  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int e0, b;
        e0 = n_err_pulse;
        out_idx = 0; t_first = -1; t_lastout = -1;
        if (v.exp_nout > 0) begin
            run_model(v.bin);
            for (int i = 0; i < NN; i++) sb_q.push_back('{m_re[i], m_im[i], (i == NN - 1)});
        end
        send_frame(v.bin, v.gap, v.nbins, v.last_idx);
        if (v.exp_nout > 0) begin
            b = 0;
            while (out_idx < NN && b < 3000) begin @(negedge clk); b++; end
            chk({v.name, "_out_count"}, out_idx, NN, 0);
            chk({v.name, "_lat_first"}, t_first - t_xfer, 1026, 0);
            chk({v.name, "_lat_last"}, t_lastout - t_xfer, 1281, 0);
            chk({v.name, "_probe_re"}, cap_re[v.probe_n], v.probe_re, 2);
            chk({v.name, "_probe_im"}, cap_im[v.probe_n], v.probe_im, 2);
        end else begin
            repeat (1400) @(negedge clk);
            chk({v.name, "_no_output"}, out_idx, 0, 0);
        end
        chk({v.name, "_frame_err_pulses"}, n_err_pulse - e0, v.exp_err, 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int bad, e0, b;
        vecs[0] = '{"dc",          0, 0, 256, 255, 0, 256,   0,  127,   0};
        vecs[1] = '{"tone",        1, 0, 256, 255, 0, 256,  64,    0, 127};
        vecs[2] = '{"short",       0, 0, 101, 100, 1,   0,   0,    0,   0};
        vecs[3] = '{"dc_after",    0, 0, 256, 255, 0, 256, 255,  127,   0};
        vecs[4] = '{"tone_thr",    1, 2, 256, 255, 0, 256, 128, -127,   0};
        vecs[5] = '{"no_last",     0, 0, 256,  -1, 1, 256,  17,  127,   0};
        vecs[6] = '{"after_rst",   1, 0, 256, 255, 0, 256,   0,  127,   0};

        x_valid = 1'b0; x_last = 1'b0; x_re = '0; x_im = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x_ready", int'(x_ready), 0, 0);
        chk("rst_y_valid", int'(y_valid), 0, 0);
        chk("rst_y_last", int'(y_last), 0, 0);
        chk("rst_frame_err", int'(frame_err), 0, 0);
        chk("rst_y_re", int'(y_re), 0, 0);
        chk("rst_y_im", int'(y_im), 0, 0);
        rst_n = 1'b1;
        #1 chk("rel_x_ready_before_edge", int'(x_ready), 0, 0);
        @(negedge clk);
        chk("rel_x_ready_after_edge", int'(x_ready), 1, 0);

        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // Reset in the middle of COMPUTE, with x_valid held high while busy.
        e0 = n_err_pulse;
        out_idx = 0;
        send_frame(1, 0, 256, 255);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            x_valid = 1'b1; x_last = 1'b1;
            @(negedge clk);
            if (x_ready) bad++;
        end
        x_valid = 1'b0; x_last = 1'b0;
        chk("busy_x_ready_cycles", bad, 0, 0);
        chk("busy_no_frame_err", n_err_pulse - e0, 0, 0);
        b = 0;
        while (cyc < t_xfer + 501 && b < 2000) begin @(negedge clk); b++; end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_y_re", int'(y_re), 0, 0);
        chk("mid_rst_y_valid", int'(y_valid), 0, 0);
        chk("mid_rst_x_ready", int'(x_ready), 0, 0);
        chk("mid_rst_no_output", out_idx, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_x_ready", int'(x_ready), 1, 0);
        run_vec(vecs[6]);

        chk("scoreboard_empty", sb_q.size(), 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
